hb3_speed_regulator: RTL and testbench
======================================

Name: hb3_speed_regulator

Overview:
Closed-loop speed regulator that sits directly upstream of the Pmod HB3 peripheral.
- Consumes the measured RPM word and a per-update strobe from the tachometer path.
- Produces the 8-bit duty-cycle and 8-bit control words that drive the PWM/direction stage.
- Runs a PI law per RPM sample and sequences safe direction reversal: ramp-down, dead time, flip.
- Detects motor stall.

Parameters:
DUTY_W, 8, duty-cycle width
KP_SHIFT, 2, proportional gain = 2^-KP_SHIFT
KI_SHIFT, 4, integral gain = 2^-KI_SHIFT
INT_LIM, 4096, integrator saturation magnitude (symmetric)
RAMP_STEP, 4, duty decrement per ramp tick
RAMP_DIV, 1000, clk cycles per ramp tick
DEAD_CYCLES, 5000, clk cycles at duty 0 before direction flip
STALL_DUTY, 128, duty threshold for stall check
STALL_SAMPLES, 3, consecutive stalled samples before fault

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; 1 = regulate, 0 = controlled stop
target_rpm  in  16  requested speed magnitude
target_dir  in  1  requested direction
rpm_in  in  32  measured RPM from tachometer
rpm_valid  in  1  one-cycle strobe: rpm_in is a new sample
duty_out  out  8  duty cycle to the PWM stage
control_out  out  8  bit0 = direction, bits 7:1 = 0
state_out  out  3  current FSM state encoding
fault  out  1  stall fault latched

Behaviour:
Reset (async, active-high):
- duty_out=0, control_out=0, fault=0, state=IDLE.
- Integrator, ramp counter, dead counter and stall counter all cleared.
- Reset mid-operation aborts any sequence immediately.

States: IDLE(0), RUN(1), BRAKE(2), DEAD(3), FAULT(4).

IDLE:
- duty 0.
- enable=1 → load control_out[0]=target_dir, clear integrator → RUN.

RUN:
- enable=0 → BRAKE (stop).
- target_dir ≠ control_out[0] → BRAKE (reverse).
- The BRAKE reason is latched on entry and does not change afterwards.

Control law, computed only in RUN on rpm_valid:
- Pipeline stage 1:
  - rpm_sat = min(rpm_in, 65535).
  - err = target_rpm − rpm_sat, signed 18-bit.
  - integ = clamp(integ + err, −INT_LIM, +INT_LIM).
- Pipeline stage 2:
  - u = (err >>> KP_SHIFT) + (integ >>> KI_SHIFT), arithmetic shifts.
  - duty_out = clamp(u, 0, 255).
- Latency: duty_out updates on the 2nd rising edge after the rpm_valid cycle.
- If rpm_valid falls on consecutive cycles, each sample is processed in order.
- If the state leaves RUN while a sample is in flight, the stage-2 result is discarded.

Stall check, in RUN on rpm_valid:
- Stalled sample: duty_out ≥ STALL_DUTY and rpm_in == 0.
- Count consecutive stalled samples; any non-stalled sample clears the count.
- Count reaching STALL_SAMPLES → FAULT.

BRAKE:
- rpm_valid is ignored; the integrator is frozen.
- Every RAMP_DIV cycles, duty_out −= RAMP_STEP, saturating at 0.
- Exit once duty_out == 0 (same cycle the ramp tick reaches 0):
  - reverse → DEAD.
  - stop → IDLE.
- If duty_out is already 0 on entry, exit on the next cycle.

DEAD:
- duty 0; count DEAD_CYCLES.
- On completion: control_out[0] = target_dir sampled at that cycle, integrator cleared.
  - enable=1 → RUN.
  - enable=0 → IDLE.
- If target_dir reverts during DEAD, the flip uses the current value; no second dead period.

FAULT:
- duty_out=0, fault=1, direction held.
- Stays until enable=0, then → IDLE with fault cleared.

Simultaneous events:
- enable fall and dir change in the same cycle → stop reason.
- rpm_valid in the cycle of a RUN→BRAKE transition → ignored.

Decomposition:
Package hb3_pkg holds:
- state enum typedef.
- CTRL_DIR_BIT constant.
- Default gain/timing localparams, shared with the HB3 top.

One natural sub-module, hb3_pi_core:
- Holds the two-stage PI pipeline, integrator clamp and duty saturation.
- Has a clear/hold input from the FSM.

The FSM, ramp/dead counters and stall counter stay in the top.

Test Plan:
- Reset, then enable=1, target_dir=1, target_rpm=100, rpm_in=0 strobe → duty_out=(100>>2)+(100>>4)=31 two cycles after strobe; control_out=0x01.
- Repeated rpm_in=0 strobes → integrator clamps at 4096; duty_out saturates at 255, never wraps. Then rpm_in=70000 → rpm saturated to 65535; duty_out clamps to 0.
- In RUN with duty 200, set target_dir=0 → ramp of 4 per 1000 cycles to 0 (50 ticks); 5000 cycles in DEAD; control_out=0x00; RUN with integrator 0.
- duty_out≥128 and three consecutive rpm_in=0 strobes → FAULT, duty 0, fault=1. enable=0 → IDLE, fault=0. Two stalled strobes then one nonzero → no fault.
- enable falls mid-DEAD → IDLE after the dead count, direction flipped, duty 0. Assert reset mid-BRAKE → all outputs 0 asynchronously.
- rpm_valid during BRAKE and rpm_valid in the RUN→BRAKE transition cycle → duty_out and integrator unchanged apart from the ramp.

Source files
------------

// File: rtl/hb3_pkg.sv
// Shared types and default tuning for the Pmod HB3 speed regulator.
// The gain and timing defaults are reused by the regulator top and the PI core.
package hb3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_BRAKE = 3'd2,
    ST_DEAD  = 3'd3,
    ST_FAULT = 3'd4
  } hb3_state_t;

  localparam int CTRL_DIR_BIT = 0;

  localparam int DEF_DUTY_W        = 8;
  localparam int DEF_KP_SHIFT      = 2;
  localparam int DEF_KI_SHIFT      = 4;
  localparam int DEF_INT_LIM       = 4096;
  localparam int DEF_RAMP_STEP     = 4;
  localparam int DEF_RAMP_DIV      = 1000;
  localparam int DEF_DEAD_CYCLES   = 5000;
  localparam int DEF_STALL_DUTY    = 128;
  localparam int DEF_STALL_SAMPLES = 3;

endpackage

// File: rtl/hb3_pi_core.sv
// Two-stage PI pipeline: stage 1 forms the error and clamped integral,
// stage 2 combines the shifted terms and saturates to a duty word.
module hb3_pi_core
  import hb3_pkg::*;
#(
  parameter int DUTY_W   = DEF_DUTY_W,
  parameter int KP_SHIFT = DEF_KP_SHIFT,
  parameter int KI_SHIFT = DEF_KI_SHIFT,
  parameter int INT_LIM  = DEF_INT_LIM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [15:0]       target_rpm,
  input  logic [31:0]       rpm_in,
  output logic              duty_valid,
  output logic [DUTY_W-1:0] duty
);

  // 20 bits holds integ + err (|err| <= 65535, |integ| <= INT_LIM) without overflow.
  localparam int ACC_W = 20;
  localparam logic signed [ACC_W-1:0] LIM_P    = ACC_W'(INT_LIM);
  localparam logic signed [ACC_W-1:0] LIM_N    = ACC_W'(-INT_LIM);
  localparam logic signed [ACC_W-1:0] DUTY_MAX = ACC_W'((1 << DUTY_W) - 1);

  logic [15:0]             rpm_sat;
  logic signed [17:0]      err;
  logic signed [17:0]      err_q;
  logic signed [ACC_W-1:0] integ;
  logic signed [ACC_W-1:0] integ_sum;
  logic signed [ACC_W-1:0] integ_next;
  logic signed [ACC_W-1:0] err_ext;
  logic signed [ACC_W-1:0] u;
  logic                    s1_valid;

  assign rpm_sat   = (rpm_in > 32'd65535) ? 16'hFFFF : rpm_in[15:0];
  assign err       = $signed({2'b00, target_rpm}) - $signed({2'b00, rpm_sat});
  assign integ_sum = integ + {{(ACC_W-18){err[17]}}, err};

  always_comb begin
    integ_next = integ_sum;
    if (integ_sum > LIM_P) begin
      integ_next = LIM_P;
    end else if (integ_sum < LIM_N) begin
      integ_next = LIM_N;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q    <= '0;
      integ    <= '0;
      s1_valid <= 1'b0;
    end else if (clear) begin
      err_q    <= '0;
      integ    <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= sample_valid;
      if (sample_valid) begin
        err_q <= err;
        integ <= integ_next;
      end
    end
  end

  assign err_ext    = {{(ACC_W-18){err_q[17]}}, err_q};
  assign u          = (err_ext >>> KP_SHIFT) + (integ >>> KI_SHIFT);
  assign duty_valid = s1_valid;

  always_comb begin
    duty = u[DUTY_W-1:0];
    if (u[ACC_W-1]) begin
      duty = '0;
    end else if (u > DUTY_MAX) begin
      duty = DUTY_MAX[DUTY_W-1:0];
    end
  end

endmodule

// File: rtl/hb3_speed_regulator.sv
// Closed-loop HB3 speed regulator: run/brake/dead-time/fault sequencing
// around the PI core, with stall detection on the tachometer samples.
module hb3_speed_regulator
  import hb3_pkg::*;
#(
  parameter int DUTY_W        = DEF_DUTY_W,
  parameter int KP_SHIFT      = DEF_KP_SHIFT,
  parameter int KI_SHIFT      = DEF_KI_SHIFT,
  parameter int INT_LIM       = DEF_INT_LIM,
  parameter int RAMP_STEP     = DEF_RAMP_STEP,
  parameter int RAMP_DIV      = DEF_RAMP_DIV,
  parameter int DEAD_CYCLES   = DEF_DEAD_CYCLES,
  parameter int STALL_DUTY    = DEF_STALL_DUTY,
  parameter int STALL_SAMPLES = DEF_STALL_SAMPLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0]       target_rpm,
  input  logic              target_dir,
  input  logic [31:0]       rpm_in,
  input  logic              rpm_valid,
  output logic [DUTY_W-1:0] duty_out,
  output logic [7:0]        control_out,
  output logic [2:0]        state_out,
  output logic              fault
);

  localparam int RAMP_W  = $clog2(RAMP_DIV + 1);
  localparam int DEAD_W  = $clog2(DEAD_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_SAMPLES + 1);
  localparam logic [RAMP_W-1:0]  RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0]  DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_HIT = STALL_W'(STALL_SAMPLES);
  localparam logic [DUTY_W-1:0]  STEP_D    = DUTY_W'(RAMP_STEP);
  localparam logic [DUTY_W-1:0]  STALL_D   = DUTY_W'(STALL_DUTY);

  hb3_state_t          state;
  hb3_state_t          state_next;
  logic                dir;
  logic                brake_rev;
  logic [RAMP_W-1:0]   ramp_cnt;
  logic [DEAD_W-1:0]   dead_cnt;
  logic [STALL_W-1:0]  stall_cnt;
  logic [STALL_W-1:0]  stall_cnt_next;
  logic [DUTY_W-1:0]   duty_next;
  logic [DUTY_W-1:0]   duty_ramped;
  logic                ramp_tick;
  logic                dead_done;
  logic                stalled;
  logic                pi_clear;
  logic                pi_sample;
  logic                pi_valid;
  logic [DUTY_W-1:0]   pi_duty;

  assign ramp_tick   = (state == ST_BRAKE) && (ramp_cnt == RAMP_LAST);
  assign dead_done   = (state == ST_DEAD) && (dead_cnt == DEAD_LAST);
  assign stalled     = (duty_out >= STALL_D) && (rpm_in == '0);
  assign duty_ramped = (duty_out > STEP_D) ? duty_out - STEP_D : '0;

  always_comb begin
    stall_cnt_next = stall_cnt;
    if (rpm_valid) begin
      stall_cnt_next = stalled ? stall_cnt + STALL_W'(1) : '0;
    end
  end

  // Stop wins over reverse when both are requested in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!enable || (target_dir != dir)) begin
          state_next = ST_BRAKE;
        end else if (rpm_valid && (stall_cnt_next == STALL_HIT)) begin
          state_next = ST_FAULT;
        end
      end
      ST_BRAKE: begin
        if ((duty_out == '0) || (ramp_tick && (duty_out <= STEP_D))) begin
          state_next = brake_rev ? ST_DEAD : ST_IDLE;
        end
      end
      ST_DEAD: begin
        if (dead_done) state_next = enable ? ST_RUN : ST_IDLE;
      end
      ST_FAULT: begin
        if (!enable) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A PI result lands only while staying in RUN, so in-flight samples die on exit.
  always_comb begin
    duty_next = duty_out;
    case (state)
      ST_RUN: begin
        if (state_next == ST_FAULT) begin
          duty_next = '0;
        end else if ((state_next == ST_RUN) && pi_valid) begin
          duty_next = pi_duty;
        end
      end
      ST_BRAKE: begin
        if (ramp_tick) duty_next = duty_ramped;
      end
      default: duty_next = '0;
    endcase
  end

  assign pi_sample = rpm_valid && (state == ST_RUN) && (state_next == ST_RUN);
  assign pi_clear  = (state == ST_IDLE) || (state == ST_DEAD) || (state == ST_FAULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      dir       <= 1'b0;
      brake_rev <= 1'b0;
      ramp_cnt  <= '0;
      dead_cnt  <= '0;
      stall_cnt <= '0;
      duty_out  <= '0;
    end else begin
      state    <= state_next;
      duty_out <= duty_next;
      if (((state == ST_IDLE) && enable) || dead_done) begin
        dir <= target_dir;
      end
      if ((state == ST_RUN) && (state_next == ST_BRAKE)) begin
        brake_rev <= enable;
      end
      ramp_cnt  <= ((state == ST_BRAKE) && !ramp_tick) ? ramp_cnt + RAMP_W'(1) : '0;
      dead_cnt  <= ((state == ST_DEAD) && !dead_done) ? dead_cnt + DEAD_W'(1) : '0;
      stall_cnt <= ((state == ST_RUN) && (state_next == ST_RUN)) ? stall_cnt_next : '0;
    end
  end

  hb3_pi_core #(
    .DUTY_W  (DUTY_W),
    .KP_SHIFT(KP_SHIFT),
    .KI_SHIFT(KI_SHIFT),
    .INT_LIM (INT_LIM)
  ) u_pi (
    .clk         (clk),
    .reset       (reset),
    .clear       (pi_clear),
    .sample_valid(pi_sample),
    .target_rpm  (target_rpm),
    .rpm_in      (rpm_in),
    .duty_valid  (pi_valid),
    .duty        (pi_duty)
  );

  always_comb begin
    control_out               = '0;
    control_out[CTRL_DIR_BIT] = dir;
  end

  assign state_out = state;
  assign fault     = (state == ST_FAULT);

endmodule

// File: tb/tb_hb3_speed_regulator.sv
// Directed bench for hb3_speed_regulator with hand-computed expectations
// for the PI law, ramp/dead sequencing, stall fault and reset behaviour.
module tb_hb3_speed_regulator;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] target_rpm;
  logic        target_dir;
  logic [31:0] rpm_in;
  logic        rpm_valid;
  logic [7:0]  duty_out;
  logic [7:0]  control_out;
  logic [2:0]  state_out;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_BRAKE = 3'd2;
  localparam logic [2:0] S_DEAD  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  hb3_speed_regulator dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .target_rpm (target_rpm),
    .target_dir (target_dir),
    .rpm_in     (rpm_in),
    .rpm_valid  (rpm_valid),
    .duty_out   (duty_out),
    .control_out(control_out),
    .state_out  (state_out),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic dir, input logic [15:0] tgt);
    enable     = en;
    target_dir = dir;
    target_rpm = tgt;
  endtask

  // One-cycle strobe, then wait until the second edge after it.
  task automatic send_sample(input logic [31:0] rpm);
    rpm_in    = rpm;
    rpm_valid = 1'b1;
    step(1);
    rpm_valid = 1'b0;
    step(1);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    reset     = 1'b1;
    rpm_in    = '0;
    rpm_valid = 1'b0;
    apply_stimulus(1'b0, 1'b0, 16'd0);
    step(2);
    check_output("reset_duty", duty_out, 0);
    check_output("reset_ctrl", control_out, 0);
    check_output("reset_state", state_out, S_IDLE);
    check_output("reset_fault", fault, 0);
    reset = 1'b0;
    step(1);

    apply_stimulus(1'b1, 1'b1, 16'd100);
    step(1);
    check_output("run_state", state_out, S_RUN);
    check_output("run_ctrl", control_out, 8'h01);
    send_sample(32'd0);
    check_output("pi_first_31", duty_out, 31);

    apply_stimulus(1'b1, 1'b1, 16'd1000);
    send_sample(32'd1);
    check_output("pi_sat_255", duty_out, 255);
    repeat (4) send_sample(32'd1);
    check_output("pi_sat_hold", duty_out, 255);
    send_sample(32'd1004);
    check_output("integ_clamp_254", duty_out, 254);
    send_sample(32'd70000);
    check_output("neg_clamp_0", duty_out, 0);
    apply_stimulus(1'b1, 1'b1, 16'd65535);
    send_sample(32'd70000);
    check_output("rpm_sat_0", duty_out, 0);

    apply_stimulus(1'b0, 1'b1, 16'd640);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    check_output("rereset_state", state_out, S_IDLE);
    apply_stimulus(1'b1, 1'b1, 16'd640);
    step(1);
    send_sample(32'd0);
    check_output("duty_200", duty_out, 200);

    // Reverse with a sample in the same cycle and one more during the ramp.
    target_dir = 1'b0;
    rpm_in     = 32'd0;
    rpm_valid  = 1'b1;
    step(1);
    rpm_valid = 1'b0;
    check_output("brake_state", state_out, S_BRAKE);
    check_output("brake_entry_duty", duty_out, 200);
    step(2);
    rpm_valid = 1'b1;
    step(1);
    rpm_valid = 1'b0;
    step(996);
    check_output("ramp_before_tick", duty_out, 200);
    step(1);
    check_output("ramp_first_tick", duty_out, 196);
    step(48999);
    check_output("ramp_last_brake", state_out, S_BRAKE);
    check_output("ramp_duty_4", duty_out, 4);
    step(1);
    check_output("dead_state", state_out, S_DEAD);
    check_output("dead_duty", duty_out, 0);
    check_output("dead_ctrl_held", control_out, 8'h01);
    step(4999);
    check_output("dead_end_state", state_out, S_DEAD);
    step(1);
    check_output("flip_state", state_out, S_RUN);
    check_output("flip_ctrl", control_out, 8'h00);
    send_sample(32'd0);
    check_output("integ_cleared", duty_out, 200);

    send_sample(32'd0);
    check_output("stall1_state", state_out, S_RUN);
    send_sample(32'd0);
    check_output("stall2_state", state_out, S_RUN);
    send_sample(32'd0);
    check_output("fault_state", state_out, S_FAULT);
    check_output("fault_duty", duty_out, 0);
    check_output("fault_flag", fault, 1);
    check_output("fault_ctrl", control_out, 8'h00);
    apply_stimulus(1'b0, 1'b0, 16'd640);
    step(1);
    check_output("fault_exit_state", state_out, S_IDLE);
    check_output("fault_cleared", fault, 0);

    apply_stimulus(1'b1, 1'b0, 16'd640);
    step(1);
    send_sample(32'd0);
    check_output("nofault_duty", duty_out, 200);
    send_sample(32'd0);
    send_sample(32'd0);
    send_sample(32'd1);
    send_sample(32'd0);
    send_sample(32'd0);
    check_output("nofault_state", state_out, S_RUN);
    check_output("nofault_flag", fault, 0);

    // Enable fall and direction change together must be treated as a stop.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    apply_stimulus(1'b1, 1'b1, 16'd0);
    step(1);
    apply_stimulus(1'b0, 1'b0, 16'd0);
    step(1);
    check_output("simul_brake", state_out, S_BRAKE);
    step(1);
    check_output("simul_idle", state_out, S_IDLE);
    check_output("simul_ctrl", control_out, 8'h01);

    apply_stimulus(1'b1, 1'b0, 16'd0);
    step(1);
    check_output("md_run_ctrl", control_out, 8'h00);
    apply_stimulus(1'b1, 1'b1, 16'd0);
    step(2);
    check_output("md_dead", state_out, S_DEAD);
    step(2000);
    apply_stimulus(1'b0, 1'b1, 16'd0);
    step(2999);
    check_output("md_still_dead", state_out, S_DEAD);
    step(1);
    check_output("md_idle", state_out, S_IDLE);
    check_output("md_ctrl_flip", control_out, 8'h01);
    check_output("md_duty", duty_out, 0);

    apply_stimulus(1'b1, 1'b1, 16'd640);
    step(1);
    send_sample(32'd0);
    check_output("rb_duty_200", duty_out, 200);
    apply_stimulus(1'b0, 1'b1, 16'd640);
    step(10);
    check_output("rb_brake", state_out, S_BRAKE);
    #2;
    reset = 1'b1;
    #1;
    check_output("rb_duty", duty_out, 0);
    check_output("rb_ctrl", control_out, 0);
    check_output("rb_state", state_out, S_IDLE);
    check_output("rb_fault", fault, 0);
    step(1);
    reset = 1'b0;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
